// File: rtl/dcache_lookup_pipe_if.sv
// Handshake/bus bundle between the D-cache control FSM, the tag lookup pipe and the valid/tag arrays.
interface dcache_lookup_pipe_if #(
  parameter int unsigned WAYS    = 8,
  parameter int unsigned WAY_W   = 3,
  parameter int unsigned TAG_W   = 44,
  parameter int unsigned INDEX_W = 6
);
  logic                     req_valid;
  logic [INDEX_W-1:0]       req_index;
  logic [TAG_W-1:0]         req_ptag;
  logic                     req_ready;
  logic                     flush;
  logic                     arr_valid;
  logic [INDEX_W-1:0]       arr_index;
  logic [WAYS-1:0]          valid_rdata;
  logic [WAYS*TAG_W-1:0]    tag_rdata;
  logic                     fill_valid;
  logic [INDEX_W-1:0]       fill_index;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic                     rsp_hit;
  logic                     rsp_full;
  logic [WAY_W-1:0]         rsp_way;
  logic [INDEX_W-1:0]       rsp_index;
  logic [WAYS*TAG_W-1:0]    rsp_tag_all;
  logic                     rsp_multihit;

  modport master (
    output req_valid, req_index, req_ptag, flush, valid_rdata, tag_rdata,
           fill_valid, fill_index, rsp_ready,
    input  req_ready, arr_valid, arr_index, rsp_valid, rsp_hit, rsp_full,
           rsp_way, rsp_index, rsp_tag_all, rsp_multihit
  );

  modport slave (
    input  req_valid, req_index, req_ptag, flush, valid_rdata, tag_rdata,
           fill_valid, fill_index, rsp_ready,
    output req_ready, arr_valid, arr_index, rsp_valid, rsp_hit, rsp_full,
           rsp_way, rsp_index, rsp_tag_all, rsp_multihit
  );
endinterface

// File: rtl/dcache_lookup_pipe.sv
// Two-stage D-cache tag lookup: array read + tag compare/victim pick (S1), registered result (S2).
// Optional multihit detection and check enabled by defining DCACHE_LOOKUP_MULTIHIT_CHK_EN.
module dcache_lookup_pipe #(
  parameter int unsigned WAYS    = 8,
  parameter int unsigned WAY_W   = 3,
  parameter int unsigned TAG_W   = 44,
  parameter int unsigned INDEX_W = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  dcache_lookup_pipe_if.slave  bus_io
);
  localparam int unsigned NSETS = 1 << INDEX_W;

  logic                  s2_en_c, s1_adv_c, req_ready_c, accept_c;
  logic                  s1_valid_q, s1_valid_d;
  logic [INDEX_W-1:0]    s1_index_q, s1_index_d;
  logic [TAG_W-1:0]      s1_ptag_q, s1_ptag_d;
  logic                  s2_valid_q, s2_valid_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic                  rsp_full_q, rsp_full_d;
  logic [WAY_W-1:0]      rsp_way_q, rsp_way_d;
  logic [INDEX_W-1:0]    rsp_index_q, rsp_index_d;
  logic [WAYS*TAG_W-1:0] rsp_tag_all_q, rsp_tag_all_d;
  logic [WAY_W-1:0]      rr_q [NSETS];

  logic [WAYS-1:0]       hit_bits_c;
  logic [WAY_W-1:0]      hit_way_c, inv_way_c, rr_fwd_c, way_sel_c;
  logic                  any_inv_c, hit_c;

  function automatic logic [WAY_W-1:0] rr_inc(input logic [WAY_W-1:0] p);
    return (p == WAY_W'(WAYS - 1)) ? '0 : p + WAY_W'(1);
  endfunction

  always_comb begin
    s2_en_c     = ~s2_valid_q | bus_io.rsp_ready;
    s1_adv_c    = s1_valid_q & s2_en_c;
    req_ready_c = ~s1_valid_q | s2_en_c;
    accept_c    = bus_io.req_valid & req_ready_c & ~bus_io.flush;
  end

  assign bus_io.req_ready = req_ready_c;
  assign bus_io.arr_valid = accept_c;
  assign bus_io.arr_index = bus_io.req_index;

  // Tag compare, lowest hit way and lowest invalid way over the array data held for S1.
  always_comb begin
    hit_bits_c = '0;
    hit_way_c  = '0;
    inv_way_c  = '0;
    any_inv_c  = 1'b0;
    for (int i = 0; i < int'(WAYS); i++) begin
      hit_bits_c[i] = bus_io.valid_rdata[i] &
                      (bus_io.tag_rdata[i*TAG_W +: TAG_W] == s1_ptag_q);
    end
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (hit_bits_c[i]) hit_way_c = WAY_W'(i);
      if (!bus_io.valid_rdata[i]) begin
        inv_way_c = WAY_W'(i);
        any_inv_c = 1'b1;
      end
    end
    hit_c = |hit_bits_c;
  end

  // A refill committed to this set in the compute cycle is forwarded into the victim choice.
  always_comb begin
    rr_fwd_c = rr_q[s1_index_q];
    if (bus_io.fill_valid && (bus_io.fill_index == s1_index_q)) begin
      rr_fwd_c = rr_inc(rr_q[s1_index_q]);
    end
    way_sel_c = hit_c ? hit_way_c : (any_inv_c ? inv_way_c : rr_fwd_c);
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_index_d    = s1_index_q;
    s1_ptag_d     = s1_ptag_q;
    s2_valid_d    = s2_valid_q;
    rsp_hit_d     = rsp_hit_q;
    rsp_full_d    = rsp_full_q;
    rsp_way_d     = rsp_way_q;
    rsp_index_d   = rsp_index_q;
    rsp_tag_all_d = rsp_tag_all_q;
    if (bus_io.flush) begin
      s1_valid_d = 1'b0;
    end else if (req_ready_c) begin
      s1_valid_d = bus_io.req_valid;
      if (bus_io.req_valid) begin
        s1_index_d = bus_io.req_index;
        s1_ptag_d  = bus_io.req_ptag;
      end
    end
    if (bus_io.flush) begin
      s2_valid_d = 1'b0;
    end else if (s2_en_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_adv_c) begin
        rsp_hit_d     = hit_c;
        rsp_full_d    = &bus_io.valid_rdata;
        rsp_way_d     = way_sel_c;
        rsp_index_d   = s1_index_q;
        rsp_tag_all_d = bus_io.tag_rdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q    <= 1'b0;
      s1_index_q    <= '0;
      s1_ptag_q     <= '0;
      s2_valid_q    <= 1'b0;
      rsp_hit_q     <= 1'b0;
      rsp_full_q    <= 1'b0;
      rsp_way_q     <= '0;
      rsp_index_q   <= '0;
      rsp_tag_all_q <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_index_q    <= s1_index_d;
      s1_ptag_q     <= s1_ptag_d;
      s2_valid_q    <= s2_valid_d;
      rsp_hit_q     <= rsp_hit_d;
      rsp_full_q    <= rsp_full_d;
      rsp_way_q     <= rsp_way_d;
      rsp_index_q   <= rsp_index_d;
      rsp_tag_all_q <= rsp_tag_all_d;
    end
  end

  // Per-set round-robin pointers; flush leaves them alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(NSETS); s++) rr_q[s] <= '0;
    end else if (bus_io.fill_valid) begin
      rr_q[bus_io.fill_index] <= rr_inc(rr_q[bus_io.fill_index]);
    end
  end

  assign bus_io.rsp_valid   = s2_valid_q;
  assign bus_io.rsp_hit     = rsp_hit_q;
  assign bus_io.rsp_full    = rsp_full_q;
  assign bus_io.rsp_way     = rsp_way_q;
  assign bus_io.rsp_index   = rsp_index_q;
  assign bus_io.rsp_tag_all = rsp_tag_all_q;

`ifdef DCACHE_LOOKUP_MULTIHIT_CHK_EN
  logic multihit_c;
  logic rsp_multihit_q, rsp_multihit_d;

  // More than one bit set iff clearing the lowest set bit leaves something.
  always_comb begin
    multihit_c     = |(hit_bits_c & (hit_bits_c - WAYS'(1)));
    rsp_multihit_d = rsp_multihit_q;
    if (!bus_io.flush && s1_adv_c) rsp_multihit_d = multihit_c;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rsp_multihit_q <= 1'b0;
    else         rsp_multihit_q <= rsp_multihit_d;
  end

  assign bus_io.rsp_multihit = rsp_multihit_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni && s1_adv_c && !bus_io.flush) begin
      assert (!multihit_c)
        else $error("dcache_lookup_pipe: multiple ways hit in set %0d", s1_index_q);
    end
  end
`endif
`else
  assign bus_io.rsp_multihit = 1'b0;
`endif

endmodule

// File: doc/dcache_lookup_pipe.md
Name: dcache_lookup_pipe

Overview:
- Parametrised, pipelined successor to the D-cache tag lookup stage. Sits between the D-cache control FSM and the valid/tag arrays.
- Accepts lookup requests with a valid/ready handshake and issues the array read. Compares the physical tag across all ways.
- Returns hit/way/victim with registered outputs and backpressure.
- Adds per-set round-robin victim selection when the set is full, plus a pipeline flush.

Parameters:
WAYS, 8, associativity (2..16, need not be a power of two)
WAY_W, 3, way-number width, equal to ceil(log2(WAYS))
TAG_W, 44, physical tag width
INDEX_W, 6, set index width; 2^INDEX_W sets

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  lookup request valid
req_index  in  INDEX_W  set index
req_ptag  in  TAG_W  physical tag
req_ready  out  1  request accepted when req_valid&req_ready
flush  in  1  kills all in-flight lookups
arr_valid  out  1  array read strobe
arr_index  out  INDEX_W  array read index
valid_rdata  in  WAYS  per-way valid bits, returned 1 cycle after arr_valid and held until the next read
tag_rdata  in  WAYS*TAG_W  per-way tags, way i at [i*TAG_W +: TAG_W], same timing as valid_rdata
fill_valid  in  1  ctrl committed a refill to a full set; advance that set's RR pointer
fill_index  in  INDEX_W  set of the committed refill
rsp_valid  out  1  lookup result valid
rsp_ready  in  1  result consumed when rsp_valid&rsp_ready
rsp_hit  out  1  tag matched a valid way
rsp_full  out  1  all ways valid
rsp_way  out  WAY_W  hit way if hit, else victim way
rsp_index  out  INDEX_W  index of this result
rsp_tag_all  out  WAYS*TAG_W  registered copy of the set's tags
rsp_multihit  out  1  more than one way hit (see Optional Feature)

Behaviour:
- Pipeline registers S1 (index, ptag, valid) and S2 (result, valid).
- Control equations:
  - s2_en = ~s2_valid | rsp_ready
  - s1_adv = s1_valid & s2_en
  - req_ready = ~s1_valid | s2_en
- Array read: arr_valid = req_valid & req_ready & ~flush; arr_index = req_index. No array read occurs while S1 is stalled, so the array holds its data.
- S1 captures req_index/ptag on accept.
- Compare in S1 using the array data:
  - hit_bits[i] = valid_rdata[i] & (tag_i == s1_ptag)
  - hit = |hit_bits; hit way = lowest-numbered set bit
- Victim selection, when there is no hit:
  - if any way is invalid, the lowest-numbered invalid way;
  - otherwise rr_ptr[s1_index].
- rsp_full = &valid_rdata. S2 captures all fields on s1_adv.
- Latency: request accept at cycle N gives rsp_valid at N+2 with no backpressure. Throughput is 1 per cycle.
- Backpressure: S2 holds all outputs stable while rsp_valid & ~rsp_ready.
- RR pointers: array of 2^INDEX_W x WAY_W, all 0 at reset.
  - On fill_valid, rr_ptr[fill_index] increments and wraps from WAYS-1 to 0.
  - When fill_valid with fill_index == s1_index occurs in the cycle S1 computes, the victim uses the post-increment value (forwarding).
- flush: S1 and S2 valid cleared on the next edge; req_ready is still driven, but no accept and no array read occur that cycle. RR pointers are unaffected. Flush wins over a simultaneous accept or advance.
- Reset (asynchronous, any time): s1_valid=0, s2_valid=0, rsp_valid=0, rsp_hit=0, rsp_full=0, rsp_way=0, rsp_index=0, rsp_tag_all=0, rsp_multihit=0, all rr_ptr=0. req_ready=1 after reset release.
- All-invalid set: hit=0, rsp_full=0, rsp_way=0.

Optional Feature:
DCACHE_LOOKUP_MULTIHIT_CHK_EN
- Defined:
  - rsp_multihit=1 when popcount(hit_bits)>1, registered in S2 with the result.
  - Synthesis-off assertion fires on any multihit.
  - rsp_way still reports the lowest hit way.
- Undefined: popcount logic is absent and rsp_multihit is tied 0.

Test Plan:
- WAYS=8, set 5 valid=8'hFF, tag way3=44'h123, req ptag 44'h123 index 5 -> two cycles later rsp_valid=1, hit=1, way=3, full=1, index=5.
- valid=8'b1111_0101, ptag misses -> hit=0, way=1, full=0.
- Set 9 full and missing: three back-to-back misses with fill_valid/fill_index=9 after each -> rsp_way=0, then 1, then 2. With WAYS=6, eight fills wrap the pointer to 2.
- Stream 4 requests with rsp_ready held 0 for 3 cycles -> req_ready drops after 2 accepts, outputs are stable, all 4 responses arrive in order, no array re-read while stalled.
- flush asserted with S1 and S2 both valid -> rsp_valid=0 next cycle, no response for those requests, next request responds normally.
- With the macro defined, ways 2 and 6 both hold the matching tag and are valid -> hit=1, way=2, rsp_multihit=1. Without the macro, rsp_multihit=0.
